// File: rtl/pkt_sched.sv
// Packet scheduler: arbitrates the three slave FIFOs onto the formatter path.
// Optional starvation aging is compiled in with `define PKT_SCHED_AGING_EN.
module pkt_sched #(
  parameter int unsigned AGE_LIMIT = 15,
  parameter int unsigned AGE_W     = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        slv0_req_i,
  input  logic        slv1_req_i,
  input  logic        slv2_req_i,
  input  logic        slv0_val_i,
  input  logic        slv1_val_i,
  input  logic        slv2_val_i,
  input  logic [31:0] slv0_data_i,
  input  logic [31:0] slv1_data_i,
  input  logic [31:0] slv2_data_i,
  input  logic [1:0]  slv0_prio_i,
  input  logic [1:0]  slv1_prio_i,
  input  logic [1:0]  slv2_prio_i,
  input  logic [2:0]  slv0_pkglen_i,
  input  logic [2:0]  slv1_pkglen_i,
  input  logic [2:0]  slv2_pkglen_i,
  input  logic        f2a_id_req_i,
  input  logic        f2a_ack_i,
  output logic        a2s0_ack_o,
  output logic        a2s1_ack_o,
  output logic        a2s2_ack_o,
  output logic        a2f_val_o,
  output logic [31:0] a2f_data_o,
  output logic [1:0]  a2f_id_o,
  output logic [2:0]  a2f_pkglen_sel_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t          state_q, state_d;
  logic [2:0]      req, val, ack;
  logic [2:0][31:0] data;
  logic [2:0][1:0] prio;
  logic [2:0][2:0] pkglen;
  logic [2:0][2:0] eff_prio;
  logic [2:0]      best_prio;
  logic [1:0]      last_id_q, id_q, win_id, cand;
  logic [2:0]      pkglen_q;
  logic [5:0]      len_q, cnt_q;
  logic            win_found, grant, xfer, sel_val, beat, last_beat;

  if (AGE_LIMIT >= (1 << AGE_W)) begin : g_bad_age_cfg
    $error("pkt_sched: AGE_W too narrow to hold AGE_LIMIT");
  end

  assign req    = {slv2_req_i, slv1_req_i, slv0_req_i};
  assign val    = {slv2_val_i, slv1_val_i, slv0_val_i};
  assign data   = {slv2_data_i, slv1_data_i, slv0_data_i};
  assign prio   = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
  assign pkglen = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};

  function automatic logic [5:0] decode_len(input logic [2:0] code);
    case (code)
      3'd0:    return 6'd4;
      3'd1:    return 6'd8;
      3'd2:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Effective priority is shifted up by one so that 0 is free for aged channels.
`ifdef PKT_SCHED_AGING_EN
  logic [2:0][AGE_W-1:0] age_q;

  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      eff_prio[ch] = (age_q[ch] == AGE_W'(AGE_LIMIT)) ? 3'd0 : {1'b0, prio[ch]} + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      age_q <= '0;
    end else if (grant) begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        if (2'(ch) == win_id) begin
          age_q[ch] <= '0;
        end else if (req[ch] && age_q[ch] != AGE_W'(AGE_LIMIT)) begin
          age_q[ch] <= age_q[ch] + AGE_W'(1);
        end
      end
    end
  end
`else
  always_comb begin
    for (int unsigned ch = 0; ch < 3; ch++) begin
      eff_prio[ch] = {1'b0, prio[ch]} + 3'd1;
    end
  end
`endif

  // Scan in round-robin order starting after last_id; strict '<' keeps the first tie.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    best_prio = '1;
    cand      = last_id_q;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (req[cand] && (!win_found || eff_prio[cand] < best_prio)) begin
        win_found = 1'b1;
        win_id    = cand;
        best_prio = eff_prio[cand];
      end
    end
  end

  assign grant     = (state_q == ARB) && win_found;
  assign xfer      = (state_q == XFER);
  assign sel_val   = val[id_q];
  assign beat      = xfer && sel_val && f2a_ack_i;
  assign last_beat = beat && (cnt_q == len_q - 6'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (f2a_id_req_i && |req) state_d = ARB;
      ARB:     state_d = win_found ? XFER : IDLE;
      XFER:    if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (xfer) ack[id_q] = f2a_ack_i & sel_val;
  end

  assign a2s0_ack_o       = ack[0];
  assign a2s1_ack_o       = ack[1];
  assign a2s2_ack_o       = ack[2];
  assign a2f_val_o        = xfer & sel_val;
  assign a2f_data_o       = xfer ? data[id_q] : '0;
  assign a2f_id_o         = id_q;
  assign a2f_pkglen_sel_o = pkglen_q;
  assign busy_o           = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      last_id_q <= 2'd2;
      id_q      <= '0;
      pkglen_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q      <= win_id;
        last_id_q <= win_id;
        pkglen_q  <= pkglen[win_id];
        len_q     <= decode_len(pkglen[win_id]);
      end
      if (beat) cnt_q <= last_beat ? '0 : cnt_q + 6'd1;
    end
  end

endmodule

// File: tb/tb_pkt_sched.sv
// Bench for pkt_sched: FIFO models feed the DUT, a grant/beat scoreboard checks output.
module tb_pkt_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [2:0]  req, val, ack, val_mask, pop;
  logic [31:0] data [3];
  logic [1:0]  prio [3];
  logic [2:0]  pkglen [3];
  logic        f2a_id_req, f2a_ack;
  logic        a2f_val, busy;
  logic [31:0] a2f_data;
  logic [1:0]  a2f_id;
  logic [2:0]  a2f_pkglen;

  pkt_sched #(.AGE_LIMIT(3), .AGE_W(4)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
    .slv0_val_i(val[0]), .slv1_val_i(val[1]), .slv2_val_i(val[2]),
    .slv0_data_i(data[0]), .slv1_data_i(data[1]), .slv2_data_i(data[2]),
    .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
    .slv0_pkglen_i(pkglen[0]), .slv1_pkglen_i(pkglen[1]), .slv2_pkglen_i(pkglen[2]),
    .f2a_id_req_i(f2a_id_req), .f2a_ack_i(f2a_ack),
    .a2s0_ack_o(ack[0]), .a2s1_ack_o(ack[1]), .a2s2_ack_o(ack[2]),
    .a2f_val_o(a2f_val), .a2f_data_o(a2f_data), .a2f_id_o(a2f_id),
    .a2f_pkglen_sel_o(a2f_pkglen), .busy_o(busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [2:0]  pl;
    int unsigned len;
  } exp_t;

  typedef struct {
    logic [2:0]  code;
    int unsigned len;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int unsigned cnt [3];
  exp_t        sb [$];
  exp_t        cur;
  int          phase;
  int unsigned beats;
  logic        mon_en;
  logic [2:0]  exp_ack;
  vec_t        tbl [8];

  function automatic int unsigned words(input logic [2:0] c);
    case (c)
      3'd0:    return 4;
      3'd1:    return 8;
      3'd2:    return 16;
      default: return 32;
    endcase
  endfunction

  // FIFO model: req once a full packet is held, val while any word remains.
  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      req[ch]  = (cnt[ch] >= words(pkglen[ch]));
      val[ch]  = (cnt[ch] != 0) && !val_mask[ch];
      data[ch] = {8'(ch), 24'(cnt[ch])};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [2:0] pl);
    sb.push_back('{id: id, pl: pl, len: words(pl)});
  endtask

  task automatic count_beat();
    exp_ack = '0;
    if (val[cur.id] && f2a_ack) exp_ack[cur.id] = 1'b1;
    check("ack_vec", {29'd0, ack}, {29'd0, exp_ack});
    check("val_out", {31'd0, a2f_val}, {31'd0, val[cur.id]});
    if (val[cur.id]) check("data_out", a2f_data, data[cur.id]);
    if (a2f_val && f2a_ack) beats++;
  endtask

  // Runs at the negedge: IDLE -> ARB (busy rises) -> XFER (grant checked) -> IDLE.
  task automatic monitor();
    if (!mon_en) return;
    case (phase)
      0: if (busy) phase = 1;
      1: begin
        check("xfer_busy", {31'd0, busy}, 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got id %0d expected no grant", a2f_id);
          cur = '{id: a2f_id, pl: a2f_pkglen, len: 0};
        end else begin
          cur = sb.pop_front();
          check("grant_id", {30'd0, a2f_id}, {30'd0, cur.id});
          check("grant_pkglen", {29'd0, a2f_pkglen}, {29'd0, cur.pl});
        end
        beats = 0;
        phase = 2;
        count_beat();
      end
      default: begin
        if (busy) count_beat();
        else begin
          check("beat_count", beats, cur.len);
          phase = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    pop = ack;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 3; ch++) if (pop[ch] && cnt[ch] > 0) cnt[ch]--;
  endtask

  function automatic logic bench_idle();
    return (sb.size() == 0) && (phase == 0) && !busy;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget && !bench_idle(); i++) step();
    checks++;
    if (!bench_idle()) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending after %0d cycles expected 0", name, sb.size(), budget);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    mon_en = 1'b0;
    f2a_id_req = 1'b0;
    f2a_ack = 1'b0;
    val_mask = '0;
    for (int ch = 0; ch < 3; ch++) begin
      cnt[ch] = 0;
      prio[ch] = '0;
      pkglen[ch] = '0;
    end
    repeat (2) step();
    rstn = 1'b1;
    sb.delete();
    phase = 0;
    mon_en = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_val"}, {31'd0, a2f_val}, 32'd0);
    check({tag, "_ack"}, {29'd0, ack}, 32'd0);
    check({tag, "_id"}, {30'd0, a2f_id}, 32'd0);
    check({tag, "_pkglen"}, {29'd0, a2f_pkglen}, 32'd0);
    check({tag, "_data"}, a2f_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{code: 3'd0, len: 4};
    tbl[1] = '{code: 3'd1, len: 8};
    tbl[2] = '{code: 3'd2, len: 16};
    tbl[3] = '{code: 3'd3, len: 32};
    tbl[4] = '{code: 3'd4, len: 32};
    tbl[5] = '{code: 3'd5, len: 32};
    tbl[6] = '{code: 3'd6, len: 32};
    tbl[7] = '{code: 3'd7, len: 32};
    pop = '0;
    phase = 0;

    // reset and idle
    do_reset();
    f2a_id_req = 1'b1;
    repeat (10) step();
    check_quiet("idle");

    // single packet on ch1, held off until the formatter asks
    f2a_id_req = 1'b0;
    f2a_ack = 1'b1;
    cnt[1] = 4;
    repeat (5) step();
    check("holdoff_busy", {31'd0, busy}, 32'd0);
    push(2'd1, 3'd0);
    f2a_id_req = 1'b1;
    wait_done("single", 40);
    check("single_fifo_empty", cnt[1], 0);

    // priority: ch2 (prio 1) before ch0 (prio 2)
    do_reset();
    f2a_id_req = 1'b1;
    f2a_ack = 1'b1;
    prio[0] = 2'd2; prio[2] = 2'd1;
    cnt[0] = 4; cnt[2] = 4;
    push(2'd2, 3'd0); push(2'd0, 3'd0);
    wait_done("priority", 60);

    // round-robin ties: 0, 1, 2, 0
    do_reset();
    f2a_id_req = 1'b1;
    f2a_ack = 1'b1;
    cnt[0] = 8; cnt[1] = 4; cnt[2] = 4;
    push(2'd0, 3'd0); push(2'd1, 3'd0); push(2'd2, 3'd0); push(2'd0, 3'd0);
    wait_done("round_robin", 80);

    // length decode table on ch0
    for (int v = 0; v < 8; v++) begin
      pkglen[0] = tbl[v].code;
      cnt[0] = tbl[v].len;
      sb.push_back('{id: 2'd0, pl: tbl[v].code, len: tbl[v].len});
      wait_done("len_table", 80);
    end

    // pkglen change mid-packet is ignored
    pkglen[0] = 3'd0;
    cnt[0] = 4;
    push(2'd0, 3'd0);
    for (int i = 0; i < 10 && !busy; i++) step();
    repeat (2) step();
    pkglen[0] = 3'd3;
    wait_done("len_hold", 40);
    check("len_hold_pkglen", {29'd0, a2f_pkglen}, 32'd0);
    check("len_hold_fifo", cnt[0], 0);
    pkglen[0] = 3'd0;

    // backpressure: toggling ack, val dropped for 3 cycles
    do_reset();
    f2a_id_req = 1'b1;
    pkglen[1] = 3'd1;
    cnt[1] = 8;
    push(2'd1, 3'd1);
    for (int k = 0; k < 200 && !bench_idle(); k++) begin
      f2a_ack = k[0];
      val_mask[1] = (k >= 6 && k < 9);
      step();
    end
    val_mask = '0;
    check("bp_done", {31'd0, bench_idle()}, 32'd1);
    check("bp_fifo_empty", cnt[1], 0);

    // reset in the middle of a packet
    do_reset();
    f2a_id_req = 1'b1;
    f2a_ack = 1'b1;
    pkglen[0] = 3'd1;
    cnt[0] = 8;
    push(2'd0, 3'd1);
    for (int i = 0; i < 20 && !(phase == 2 && beats >= 2); i++) step();
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    mon_en = 1'b0;
    step();
    check_quiet("rst_mid");
    do_reset();

    // aging: ch2 (prio 3) against an always-requesting ch0 (prio 0)
    f2a_id_req = 1'b1;
    f2a_ack = 1'b1;
    prio[2] = 2'd3;
    cnt[0] = 16; cnt[2] = 4;
`ifdef PKT_SCHED_AGING_EN
    push(2'd0, 3'd0); push(2'd0, 3'd0); push(2'd0, 3'd0); push(2'd2, 3'd0); push(2'd0, 3'd0);
`else
    push(2'd0, 3'd0); push(2'd0, 3'd0); push(2'd0, 3'd0); push(2'd0, 3'd0); push(2'd2, 3'd0);
`endif
    wait_done("aging", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_sched.md
# pkt_sched

Packet scheduler that shares the MCDF formatter between the three slave FIFOs. It picks one requesting channel per packet, using the register-programmed priority with a round-robin tie-break. It then steers that channel's data and valid onto the formatter path and routes the formatter's ack back, counting beats until the programmed packet length is done. It sits between the three `slave_fifo` instances and `formater`, and takes its priority and length configuration from `ctrl_regs`.

## Interface
Parameters:
- `AGE_LIMIT`, default 15: number of lost arbitrations after which a waiting channel is promoted. Used only with aging compiled in.
- `AGE_W`, default 4: width of each age counter. Must satisfy 2^AGE_W > AGE_LIMIT.

Ports:
- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, synchronous, active-low.
- `slv0_req_i`/`slv1_req_i`/`slv2_req_i` in 1 each: the channel FIFO holds at least one full packet.
- `slv0_val_i`/`slv1_val_i`/`slv2_val_i` in 1 each: FIFO head word is valid.
- `slv0_data_i`/`slv1_data_i`/`slv2_data_i` in 32 each: FIFO head word.
- `slv0_prio_i`/`slv1_prio_i`/`slv2_prio_i` in 2 each: priority; 0 is highest.
- `slv0_pkglen_i`/`slv1_pkglen_i`/`slv2_pkglen_i` in 3 each: packet-length code.
- `f2a_id_req_i` in 1: the formatter is ready for a new packet.
- `f2a_ack_i` in 1: the formatter accepts the current word.
- `a2s0_ack_o`/`a2s1_ack_o`/`a2s2_ack_o` out 1 each: pop strobe to a FIFO.
- `a2f_val_o` out 1: word valid to the formatter.
- `a2f_data_o` out 32: word to the formatter.
- `a2f_id_o` out 2: granted channel id (0..2).
- `a2f_pkglen_sel_o` out 3: granted channel's length code.
- `busy_o` out 1: a packet is in progress.

## Operation
- States: IDLE, ARB, XFER.
- **IDLE:**
  - If `f2a_id_req_i`=1 and any `slvN_req_i`=1, go to ARB. Otherwise stay in IDLE.
- **ARB (one cycle):**
  - Winner = requesting channel with the numerically lowest effective priority.
  - Ties go to the first tied channel after `last_id` in order 0→1→2→0.
  - Register the winner into `a2f_id_o`, `last_id` and `len_q`, and capture its `pkglen_i` into `a2f_pkglen_sel_o`.
  - If no request is still asserted in ARB, return to IDLE with no grant.
  - Otherwise go to XFER.
- **Length decode (`len_q`):**
  - Code 0 → 4 words, 1 → 8, 2 → 16, 3 → 32.
  - Codes 4..7 → 32 words.
  - The code is sampled once in ARB. Changing `pkglen_i` mid-packet has no effect on the current packet.
- **XFER:**
  - `a2f_val_o` = `slv[id]_val_i`.
  - `a2f_data_o` = `slv[id]_data_i`.
  - `a2s[id]_ack_o` = `f2a_ack_i & slv[id]_val_i`. Non-selected acks are 0.
  - A beat is a cycle with `a2f_val_o & f2a_ack_i`.
  - The 6-bit beat counter increments on each beat.
  - On the beat where count = `len_q`−1, clear the counter and return to IDLE.
- **Outside XFER:**
  - `a2f_val_o`=0 and all acks = 0.
  - `a2f_data_o` = 0.
- `busy_o` = 1 in ARB and XFER.
- A FIFO dropping `req` during XFER does not abort the packet; the scheduler waits on `val`.
- `f2a_ack_i` without `val` is ignored.

## Timing
- Reset values:
  - state = IDLE, all outputs 0.
  - `last_id` = 2, so channel 0 wins the first tie.
  - Beat counter and age counters = 0.
- Sync reset in ARB or XFER aborts the packet on the next edge. There is no partial-packet recovery.
- Grant latency: `f2a_id_req_i` and `req` high in IDLE at edge *t* → ARB at *t*+1 → XFER with `a2f_id_o` valid at *t*+2.
- Ack and data paths are combinational from the inputs in XFER (zero-cycle pass-through).
- Back-to-back packets: minimum 2 idle cycles (IDLE, ARB) between the last beat and the next first beat.
- `a2f_id_o` and `a2f_pkglen_sel_o` hold from ARB until the next ARB.

## Configuration
- Macro: `PKT_SCHED_AGING_EN`.
- **Defined:**
  - Each channel has an `AGE_W`-bit age counter.
  - In ARB, every requesting non-winner increments its counter, saturating at `AGE_LIMIT`. The winner's counter clears.
  - A channel whose counter equals `AGE_LIMIT` has effective priority −1, i.e. it beats any non-aged channel.
  - Several aged channels are resolved by round-robin.
- **Undefined:**
  - No age counters.
  - Effective priority = `prio_i`; starvation of low-priority channels is permitted.

## Test plan
- **Reset and idle:** reset, no requests for 10 cycles → all outputs 0, `busy_o`=0.
- **Single packet:** ch1 req, prio 0, pkglen 0, `f2a_id_req_i`=1, ack always 1 → `a2f_id_o`=1 two cycles later, `a2f_pkglen_sel_o`=0, exactly 4 `a2s1_ack_o` pulses, then IDLE.
- **Priority:** ch0 prio 2, ch2 prio 1, both req → ch2 granted first, ch0 next.
- **Round-robin ties:** all three req at prio 0, three packets → grant order 0, 1, 2; fourth packet → 0.
- **Backpressure:** pkglen 1 (8 words), `f2a_ack_i` toggling and `val` dropping for 3 cycles → exactly 8 beats, no ack on cycles without val. Assert reset mid-XFER → IDLE next edge, all outputs 0.
- **Aging (`PKT_SCHED_AGING_EN`):** ch0 prio 0 always req, ch2 prio 3 req, `AGE_LIMIT`=3 → ch2 granted on the 4th arbitration. Without the macro, ch2 is never granted.
